// File: rtl/avalon_peripheral_arbiter_pkg.sv
// Shared types for the Avalon peripheral arbiter: FSM state and latched operation.
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/avalon_peripheral_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches upward from the master after last_grant_i.
module rr_arbiter #(
    parameter int MASTERS = 2,
    parameter int IDX_W   = $clog2(MASTERS)
) (
    input  logic [MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    input  logic               en_i,
    output logic [MASTERS-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_req_o
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Pick the first requesting master after last_grant_i, wrapping around.
    always_comb begin
        found_s   = 1'b0;
        cand_s    = '0;
        gnt_idx_o = '0;
        for (int i = 1; i <= MASTERS; i++) begin
            cand_s = IDX_W'((int'(last_grant_i) + i) % MASTERS);
            if (!found_s && en_i && req_i[cand_s]) begin
                found_s   = 1'b1;
                gnt_idx_o = cand_s;
            end else begin
                found_s   = found_s;
            end
        end
        if (found_s) begin
            gnt_o = MASTERS'(1) << gnt_idx_o;
        end else begin
            gnt_o = '0;
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/avalon_peripheral_arbiter.sv
// Shares one Avalon-style peripheral register port between MASTERS masters,
// one access at a time, with round-robin grant and a read timeout.
module avalon_peripheral_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int                MASTERS  = 2,
    parameter int                ADDR_W   = 2,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [MASTERS-1:0]             m_read,
    input  logic [MASTERS-1:0]             m_write,
    input  logic [MASTERS-1:0][ADDR_W-1:0] m_address,
    input  logic [MASTERS-1:0][DATA_W-1:0] m_data_in,
    output logic [MASTERS-1:0]             m_waitrequest,
    output logic [MASTERS-1:0]             m_read_valid,
    output logic [DATA_W-1:0]              m_data_out,
    output logic                           s_read,
    output logic                           s_write,
    output logic [ADDR_W-1:0]              s_address,
    output logic [DATA_W-1:0]              s_data_in,
    input  logic                           s_read_valid,
    input  logic [DATA_W-1:0]              s_data_out,
    output logic                           timeout_err
);

    localparam int IDX_W = $clog2(MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t               state_q, state_d;
    op_t                  op_q, op_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 s_read_q, s_read_d, s_write_q, s_write_d;
    logic [ADDR_W-1:0]    s_address_q, s_address_d;
    logic [DATA_W-1:0]    s_data_in_q, s_data_in_d;
    logic [MASTERS-1:0]   m_read_valid_q, m_read_valid_d;
    logic [DATA_W-1:0]    m_data_out_q, m_data_out_d;
    logic                 timeout_q, timeout_d;

    logic [MASTERS-1:0]   gnt_s;
    logic [IDX_W-1:0]     gnt_idx_s;
    logic                 any_req_s;
    logic                 arb_en_s;
    logic                 accept_s;
    logic                 rd_done_s;
    logic                 tmo_s;

    // Grants are only offered in IDLE; suppressed while reset is held.
    assign arb_en_s = (state_q == IDLE) && !reset;

    rr_arbiter #(
        .MASTERS (MASTERS),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i        (m_read | m_write),
        .last_grant_i (last_grant_q),
        .en_i         (arb_en_s),
        .gnt_o        (gnt_s),
        .gnt_idx_o    (gnt_idx_s),
        .any_req_o    (any_req_s)
    );

    assign accept_s  = arb_en_s && any_req_s;
    assign rd_done_s = s_read_valid &&
                       (((state_q == ISSUE) && (op_q == OP_READ)) || (state_q == WAIT_RD));
    // A return in the same cycle as the limit wins over the timeout.
    assign tmo_s     = (state_q == WAIT_RD) && !s_read_valid && (cnt_q == TO_CNT);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= OP_READ;
            last_grant_q   <= IDX_W'(MASTERS - 1);
            cnt_q          <= '0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            s_address_q    <= '0;
            s_data_in_q    <= '0;
            m_read_valid_q <= '0;
            m_data_out_q   <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            s_address_q    <= s_address_d;
            s_data_in_q    <= s_data_in_d;
            m_read_valid_q <= m_read_valid_d;
            m_data_out_q   <= m_data_out_d;
            timeout_q      <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (op_q == OP_WRITE || s_read_valid) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (rd_done_s || tmo_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command latch, timeout counter and registered completion outputs.
    always_comb begin
        op_d           = op_q;
        last_grant_d   = last_grant_q;
        s_address_d    = s_address_q;
        s_data_in_d    = s_data_in_q;
        s_write_d      = 1'b0;
        s_read_d       = 1'b0;
        m_read_valid_d = '0;
        m_data_out_d   = m_data_out_q;
        timeout_d      = tmo_s;

        case (state_q)
            ISSUE:   cnt_d = '0;
            WAIT_RD: cnt_d = (cnt_q == TO_CNT) ? cnt_q : cnt_q + CNT_W'(1);
            default: cnt_d = '0;
        endcase

        if (accept_s) begin
            op_d         = m_write[gnt_idx_s] ? OP_WRITE : OP_READ;
            last_grant_d = gnt_idx_s;
            s_address_d  = m_address[gnt_idx_s];
            s_data_in_d  = m_data_in[gnt_idx_s];
            s_write_d    = m_write[gnt_idx_s];
            s_read_d     = !m_write[gnt_idx_s];
        end else begin
            op_d         = op_q;
        end

        if (rd_done_s) begin
            m_read_valid_d = MASTERS'(1) << last_grant_q;
            m_data_out_d   = s_data_out;
        end else if (tmo_s) begin
            m_read_valid_d = MASTERS'(1) << last_grant_q;
            m_data_out_d   = ERR_DATA;
        end else begin
            m_read_valid_d = '0;
        end
    end

    assign m_waitrequest = ~gnt_s;
    assign m_read_valid  = m_read_valid_q;
    assign m_data_out    = m_data_out_q;
    assign s_read        = s_read_q;
    assign s_write       = s_write_q;
    assign s_address     = s_address_q;
    assign s_data_in     = s_data_in_q;
    assign timeout_err   = timeout_q;

endmodule
